regfile_led_scanner: RTL

REGFILE_LED_SCANNER -- requirements
Module: regfile_led_scanner

---
 rtl/regfile_led_scanner_pkg.sv | 28 ++
 rtl/dwell_counter.sv | 43 ++++
 rtl/regfile_led_scanner.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/regfile_led_scanner_pkg.sv
// Shared types and constants for the register-file LED scanner.
package regfile_led_scanner_pkg;

  localparam int DWELL_DEFAULT = 50_000_000;

  localparam int INDEX_W = 3;
  localparam int DATA_W  = 16;
  localparam int LED_W   = 10;

  localparam int LED_HEARTBEAT = 9;
  localparam int LED_PHASE     = 8;

  localparam logic [INDEX_W-1:0] LAST_INDEX = 3'd7;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADDR    = 3'd1,
    CAPTURE = 3'd2,
    SHOW_HI = 3'd3,
    SHOW_LO = 3'd4,
    NEXT    = 3'd5
  } state_t;

  function automatic logic isShow(input state_t s);
    return (s == SHOW_HI) || (s == SHOW_LO);
  endfunction

endpackage

// File: rtl/dwell_counter.sv
// Wrapping cycle counter that flags the last cycle of a DWELL-long interval.
// DWELL must be at least 2.
module dwell_counter
  import regfile_led_scanner_pkg::*;
#(
  parameter int DWELL = DWELL_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic i_clear,
  input  logic i_run,
  input  logic i_force,
  output logic o_expire
);

  localparam int CW = $clog2(DWELL);
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  logic [CW-1:0] r_count;
  logic          w_atLast;

  // Expiry is the last counted cycle of the interval, or an external force.
  always_comb begin
    w_atLast = (r_count == LAST);
    o_expire = (i_run && w_atLast) || i_force;
  end

  // Count while running, wrap after the last cycle, clear has priority.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_run) begin
      if (w_atLast) begin
        r_count <= '0;
      end else begin
        r_count <= r_count + CW'(1);
      end
    end
  end

endmodule

// File: rtl/regfile_led_scanner.sv
// Walks registers 0..7 of a register file, showing each value on ten LEDs
// as a high-byte phase followed by a low-byte phase, DWELL cycles each.
module regfile_led_scanner
  import regfile_led_scanner_pkg::*;
#(
  parameter int DWELL = DWELL_DEFAULT
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic               pause,
  input  logic               step,
  input  logic [DATA_W-1:0]  rd_data,
  output logic [INDEX_W-1:0] SA,
  output logic [INDEX_W-1:0] cur_index,
  output logic [DATA_W-1:0]  cur_value,
  output logic [LED_W-1:0]   led,
  output logic               sweep_done
);

  state_t r_state;
  state_t w_nextState;

  logic [INDEX_W-1:0] r_curIndex;
  logic [DATA_W-1:0]  r_curValue;
  logic               r_ledPhase;
  logic [7:0]         r_ledByte;
  logic               r_heartbeat;

  logic w_inShow;
  logic w_dwellClear;
  logic w_dwellRun;
  logic w_dwellForce;
  logic w_dwellExpire;
  logic w_capture;
  logic w_loadLo;
  logic w_advance;
  logic w_hbRun;
  logic w_hbExpire;

  // Phase timer: restarts on every state change, frozen while paused.
  dwell_counter #(
    .DWELL (DWELL)
  ) u_dwell (
    .clock    (clock),
    .reset    (reset),
    .i_clear  (w_dwellClear),
    .i_run    (w_dwellRun),
    .i_force  (w_dwellForce),
    .o_expire (w_dwellExpire)
  );

  // Heartbeat timer: runs only while paused so the LED blinks at the dwell rate.
  dwell_counter #(
    .DWELL (DWELL)
  ) u_heartbeat (
    .clock    (clock),
    .reset    (reset),
    .i_clear  (!w_hbRun),
    .i_run    (w_hbRun),
    .i_force  (1'b0),
    .o_expire (w_hbExpire)
  );

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic; dropping enable always parks the scan in IDLE.
  always_comb begin
    w_nextState = r_state;
    if (!enable) begin
      w_nextState = IDLE;
    end else begin
      case (r_state)
        IDLE:    w_nextState = ADDR;
        ADDR:    w_nextState = CAPTURE;
        CAPTURE: w_nextState = SHOW_HI;
        SHOW_HI: if (w_dwellExpire) w_nextState = SHOW_LO;
        SHOW_LO: if (w_dwellExpire) w_nextState = NEXT;
        NEXT:    w_nextState = ADDR;
        default: w_nextState = IDLE;
      endcase
    end
  end

  // Control decode from the current and next state.
  always_comb begin
    w_inShow     = isShow(r_state);
    w_dwellRun   = w_inShow && !pause;
    w_dwellForce = w_inShow && pause && step;
    w_dwellClear = !w_inShow || (w_nextState != r_state);
    w_capture    = (r_state == CAPTURE) && (w_nextState == SHOW_HI);
    w_loadLo     = (r_state == SHOW_HI) && (w_nextState == SHOW_LO);
    w_advance    = (r_state == NEXT) && (w_nextState == ADDR);
    w_hbRun      = enable && pause;
    sweep_done   = w_advance && (r_curIndex == LAST_INDEX);
  end

  // Index, captured value and LED byte/phase; all hold while idle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_curIndex <= '0;
      r_curValue <= '0;
      r_ledPhase <= 1'b0;
      r_ledByte  <= '0;
    end else begin
      if (w_advance) begin
        r_curIndex <= r_curIndex + INDEX_W'(1);
      end
      if (w_capture) begin
        r_curValue <= rd_data;
        r_ledPhase <= 1'b1;
        r_ledByte  <= rd_data[15:8];
      end else if (w_loadLo) begin
        r_ledPhase <= 1'b0;
        r_ledByte  <= r_curValue[7:0];
      end
    end
  end

  // Heartbeat toggles each dwell interval while paused, zero when running, held while idle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_heartbeat <= 1'b0;
    end else if (enable) begin
      if (!pause) begin
        r_heartbeat <= 1'b0;
      end else if (w_hbExpire) begin
        r_heartbeat <= !r_heartbeat;
      end
    end
  end

  // Output assembly; the read address simply follows the displayed index.
  always_comb begin
    led                = '0;
    led[LED_HEARTBEAT] = r_heartbeat;
    led[LED_PHASE]     = r_ledPhase;
    led[7:0]           = r_ledByte;
    SA                 = r_curIndex;
    cur_index          = r_curIndex;
    cur_value          = r_curValue;
  end

endmodule
